micron_req_sequencer: RTL and testbench

Bus-side request sequencer sitting directly upstream of `micron_controller`. It queues CPU memory commands (single words or bursts of 1/2/4/8 words), buffers write data, and drives the controller's `baddr`/`bburst` request interface one transaction at a time. It also counts data beats against `bwait` and returns read words to the CPU. The block isolates CPU timing from the controller's variable-latency Cellular RAM accesses.

---
 rtl/micron_req_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_micron_req_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micron_req_sequencer.sv
// micron_req_sequencer: queues CPU memory commands and write data, then
// drives the micron_controller request interface one transaction at a time,
// counting data beats against bwait and returning read words to the CPU.
// Optional feature macro: MICRON_SEQ_ROW_SPLIT_EN (split row-crossing bursts
// into single-word transactions). Default build issues commands unchanged.
module micron_req_sequencer #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned WD_DEPTH  = 16
) (
  input  logic        clk50MHz,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_addr,
  input  logic [1:0]  cmd_len,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [15:0] wd_data,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        err,
  output logic [15:0] baddr,
  output logic [1:0]  bburst,
  output logic        bwe,
  output logic        breq,
  input  logic        bwait,
  input  logic        bvalid,
  output logic [15:0] bdata_out,
  input  logic [15:0] bdata_in
);

  localparam int unsigned DW  = 16;
  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned CCW = CAW + 1;
  localparam int unsigned WAW = $clog2(WD_DEPTH);
  localparam int unsigned WCW = WAW + 1;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [1:0]    len;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BEAT  = 2'd2
  } state_t;

  // Command and write-data storage
  cmd_t           r_cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] r_cmd_wptr;
  logic [CAW-1:0] r_cmd_rptr;
  logic [CCW-1:0] r_cmd_cnt;
  logic [DW-1:0]  r_wd_mem [WD_DEPTH];
  logic [WAW-1:0] r_wd_wptr;
  logic [WAW-1:0] r_wd_rptr;
  logic [WCW-1:0] r_wd_cnt;

  // Sequencer state and registered outputs
  state_t        r_state;
  logic          r_breq;
  logic          r_bwe;
  logic [DW-1:0] r_baddr;
  logic [1:0]    r_bburst;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_err;
  logic [DW-1:0] r_bdata_out;
  logic [3:0]    r_beats;
  logic          r_split;
  logic [3:0]    r_pieces;

  cmd_t           w_head;
  logic [3:0]     w_head_words;
  logic           w_cmd_push;
  logic           w_cmd_pop;
  logic           w_wd_push;
  logic [3:0]     w_wd_pop_n;
  logic [WAW-1:0] w_wd_rptr_nxt;
  logic [WCW-1:0] w_wd_cnt_nxt;
  logic           w_beat;
  logic [3:0]     w_beats_left;
  logic           w_wd_enough;
  logic           w_can_issue;
  logic           w_cross;

  assign w_head       = r_cmd_mem[r_cmd_rptr];
  assign w_head_words = 4'd1 << w_head.len;

  assign cmd_ready  = r_cmd_cnt < CCW'(CMD_DEPTH);
  assign wd_ready   = r_wd_cnt < WCW'(WD_DEPTH);
  assign w_cmd_push = cmd_valid && cmd_ready;
  assign w_wd_push  = wd_valid && wd_ready;

  // A split command stays at the head until its last piece has finished.
  assign w_cmd_pop = ((r_state == S_ISSUE) && bwait && !r_split) ||
                     ((r_state == S_BEAT) && !bwait && r_split && (r_pieces == 4'd1));

  assign w_beat       = (r_state == S_BEAT) && bvalid && (r_beats != 4'd0);
  assign w_beats_left = r_beats - (w_beat ? 4'd1 : 4'd0);

  // On an early bwait drop the whole unconsumed remainder of the burst goes.
  assign w_wd_pop_n    = ((r_state == S_BEAT) && r_bwe) ?
                         (bwait ? (w_beat ? 4'd1 : 4'd0) : r_beats) : 4'd0;
  assign w_wd_rptr_nxt = r_wd_rptr + WAW'(w_wd_pop_n);
  assign w_wd_cnt_nxt  = r_wd_cnt + WCW'(w_wd_push) - WCW'(w_wd_pop_n);

  assign w_wd_enough = r_wd_cnt >= WCW'(w_head_words);
  assign w_can_issue = (r_state == S_IDLE) && !bwait &&
                       (r_split || ((r_cmd_cnt != '0) && (!w_head.we || w_wd_enough)));

`ifdef MICRON_SEQ_ROW_SPLIT_EN
  assign w_cross = ({1'b0, w_head.addr[6:0]} + {4'd0, w_head_words}) > 8'd128;
`else
  assign w_cross = 1'b0;
`endif

  assign breq      = r_breq;
  assign baddr     = r_baddr;
  assign bburst    = r_bburst;
  assign bwe       = r_bwe;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign err       = r_err;
  assign bdata_out = r_bdata_out;

  // FIFO payload storage (no reset needed, guarded by counts)
  always_ff @(posedge clk50MHz) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wptr] <= '{we: cmd_we, addr: cmd_addr, len: cmd_len};
    if (w_wd_push)  r_wd_mem[r_wd_wptr]   <= wd_data;
  end

  // FIFO pointers/counts and registered write-data head
  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      r_cmd_wptr  <= '0;
      r_cmd_rptr  <= '0;
      r_cmd_cnt   <= '0;
      r_wd_wptr   <= '0;
      r_wd_rptr   <= '0;
      r_wd_cnt    <= '0;
      r_bdata_out <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + CAW'(1);
      if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + CAW'(1);
      r_cmd_cnt <= r_cmd_cnt + CCW'(w_cmd_push) - CCW'(w_cmd_pop);
      if (w_wd_push)  r_wd_wptr <= r_wd_wptr + WAW'(1);
      r_wd_rptr <= w_wd_rptr_nxt;
      r_wd_cnt  <= w_wd_cnt_nxt;
      if (w_wd_cnt_nxt == '0)
        r_bdata_out <= '0;
      else if (w_wd_push && (r_wd_wptr == w_wd_rptr_nxt))
        r_bdata_out <= wd_data;
      else
        r_bdata_out <= r_wd_mem[w_wd_rptr_nxt];
    end
  end

  // Request/beat sequencer with registered controller and CPU outputs
  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_breq     <= 1'b0;
      r_baddr    <= '0;
      r_bburst   <= '0;
      r_bwe      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_beats    <= '0;
      r_split    <= 1'b0;
      r_pieces   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_can_issue) begin
            r_state <= S_ISSUE;
            r_breq  <= 1'b1;
            if (!r_split) begin
              r_baddr <= w_head.addr;
              r_bwe   <= w_head.we;
              if (w_cross) begin
                r_split  <= 1'b1;
                r_pieces <= w_head_words;
                r_bburst <= 2'b00;
              end else begin
                r_bburst <= w_head.len;
              end
            end
          end
        end
        S_ISSUE: begin
          if (bwait) begin
            r_breq  <= 1'b0;
            r_state <= S_BEAT;
            r_beats <= 4'd1 << r_bburst;
          end
        end
        S_BEAT: begin
          if (w_beat && !r_bwe) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= bdata_in;
          end
          if (bvalid && (r_beats == 4'd0)) r_err <= 1'b1;
          r_beats <= w_beats_left;
          if (!bwait) begin
            r_state <= S_IDLE;
            if (w_beats_left != 4'd0) r_err <= 1'b1;
            if (r_split) begin
              r_baddr <= r_baddr + 16'd1;
              if (r_pieces == 4'd1) r_split  <= 1'b0;
              else                  r_pieces <= r_pieces - 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micron_req_sequencer.sv
// Directed self-checking bench for micron_req_sequencer; the controller side
// is driven by hand. Row-split expectations follow MICRON_SEQ_ROW_SPLIT_EN.
`timescale 1ns/1ps
module tb_micron_req_sequencer;

  logic        clk50MHz = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [15:0] wd_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        err;
  logic [15:0] baddr;
  logic [1:0]  bburst;
  logic        bwe, breq, bwait, bvalid;
  logic [15:0] bdata_out, bdata_in;

  int n_pass  = 0;
  int n_total = 0;

  micron_req_sequencer #(.CMD_DEPTH(4), .WD_DEPTH(16)) dut (
    .clk50MHz (clk50MHz),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_data  (wd_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .err      (err),
    .baddr    (baddr),
    .bburst   (bburst),
    .bwe      (bwe),
    .breq     (breq),
    .bwait    (bwait),
    .bvalid   (bvalid),
    .bdata_out(bdata_out),
    .bdata_in (bdata_in)
  );

  always #10 clk50MHz = ~clk50MHz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk50MHz);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 16'(cmd_ready), 16'h1);
    chk({tag, "_wd_ready"},  16'(wd_ready),  16'h1);
    chk({tag, "_rd_valid"},  16'(rd_valid),  16'h0);
    chk({tag, "_rd_data"},   rd_data,        16'h0);
    chk({tag, "_err"},       16'(err),       16'h0);
    chk({tag, "_breq"},      16'(breq),      16'h0);
    chk({tag, "_baddr"},     baddr,          16'h0);
    chk({tag, "_bburst"},    16'(bburst),    16'h0);
    chk({tag, "_bwe"},       16'(bwe),       16'h0);
    chk({tag, "_bdata_out"}, bdata_out,      16'h0);
  endtask

  task automatic push_wd(input logic [15:0] d);
    wd_valid = 1'b1;
    wd_data  = d;
    step();
    wd_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic we, input logic [15:0] a, input logic [1:0] l);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  // One edge from IDLE into ISSUE, check the request, then grant it.
  task automatic issue(input string tag, input logic [15:0] a, input logic [1:0] b, input logic we);
    step();
    chk({tag, "_breq"},   16'(breq),   16'h1);
    chk({tag, "_baddr"},  baddr,       a);
    chk({tag, "_bburst"}, 16'(bburst), 16'(b));
    chk({tag, "_bwe"},    16'(bwe),    16'(we));
    bwait = 1'b1;
    step();
    chk({tag, "_breq_off"}, 16'(breq), 16'h0);
  endtask

  task automatic rd_beat(input string tag, input logic [15:0] d);
    bvalid   = 1'b1;
    bdata_in = d;
    step();
    bvalid = 1'b0;
    chk({tag, "_rd_valid"}, 16'(rd_valid), 16'h1);
    chk({tag, "_rd_data"},  rd_data,       d);
  endtask

  task automatic end_txn();
    bwait  = 1'b0;
    bvalid = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; bwait = 1'b0; bvalid = 1'b0; bdata_in = '0;
    step(); step();
    chk_reset("por");
    reset = 1'b0;
    step();

    // Write burst of 4 at 0x0001
    for (int i = 0; i < 4; i++) push_wd(16'h2222 + 16'(i));
    chk("wr4_head", bdata_out, 16'h2222);
    push_cmd(1'b1, 16'h0001, 2'b10);
    chk("wr4_lat", 16'(breq), 16'h0);
    issue("wr4", 16'h0001, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("wr4_beat", bdata_out, 16'h2222 + 16'(i));
      bvalid = 1'b1;
      step();
    end
    bvalid = 1'b0;
    chk("wr4_drained", bdata_out, 16'h0);
    end_txn();
    chk("wr4_err", 16'(err), 16'h0);

    // Read burst of 2 at 0x0000
    push_cmd(1'b0, 16'h0000, 2'b01);
    issue("rd2", 16'h0000, 2'b01, 1'b0);
    rd_beat("rd2_b0", 16'hA5A5);
    step();
    chk("rd2_gap", 16'(rd_valid), 16'h0);
    rd_beat("rd2_b1", 16'h5A5A);
    end_txn();
    chk("rd2_end_valid", 16'(rd_valid), 16'h0);
    chk("rd2_err", 16'(err), 16'h0);

    // Write of 8 held until the 8th word arrives
    for (int i = 0; i < 7; i++) push_wd(16'h3000 + 16'(i));
    push_cmd(1'b1, 16'h0100, 2'b11);
    for (int i = 0; i < 3; i++) begin
      chk("wr8_hold", 16'(breq), 16'h0);
      step();
    end
    push_wd(16'h3007);
    chk("wr8_lat", 16'(breq), 16'h0);
    issue("wr8", 16'h0100, 2'b11, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("wr8_beat", bdata_out, 16'h3000 + 16'(i));
      bvalid = 1'b1;
      step();
    end
    end_txn();
    chk("wr8_err", 16'(err), 16'h0);

    // Fill the command FIFO while the controller is busy
    bwait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 16'(cmd_ready), 16'h1);
      push_cmd(1'b0, 16'h0010 + 16'(i), 2'b00);
    end
    chk("full_ready", 16'(cmd_ready), 16'h0);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0014; cmd_len = 2'b00;
    step(); step();
    chk("full_hold", 16'(cmd_ready), 16'h0);
    bwait = 1'b0;
    step();
    chk("q0_breq", 16'(breq), 16'h1);
    chk("q0_baddr", baddr, 16'h0010);
    chk("q0_ready", 16'(cmd_ready), 16'h0);
    bwait = 1'b1;
    step();
    chk("q0_popped", 16'(cmd_ready), 16'h1);
    step();
    cmd_valid = 1'b0;
    chk("q5_taken", 16'(cmd_ready), 16'h0);
    rd_beat("q0", 16'h1110);
    end_txn();
    for (int j = 0; j < 4; j++) begin
      issue("qn", 16'h0011 + 16'(j), 2'b00, 1'b0);
      rd_beat("qn", 16'h1111 + 16'(j));
      end_txn();
    end
    chk("q_empty_ready", 16'(cmd_ready), 16'h1);

    // Early bwait drop on a 4-beat read
    push_cmd(1'b0, 16'h0200, 2'b10);
    issue("short", 16'h0200, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) rd_beat("short", 16'hB000 + 16'(i));
    end_txn();
    chk("short_err", 16'(err), 16'h1);
    chk("short_no_rd", 16'(rd_valid), 16'h0);
    push_cmd(1'b0, 16'h0300, 2'b00);
    issue("after", 16'h0300, 2'b00, 1'b0);
    rd_beat("after", 16'h0BEE);
    end_txn();
    chk("err_sticky", 16'(err), 16'h1);

    // Early drop on a write discards the unused word
    push_wd(16'h4000);
    push_wd(16'h4001);
    push_cmd(1'b1, 16'h0600, 2'b01);
    issue("wshort", 16'h0600, 2'b01, 1'b1);
    chk("wshort_b0", bdata_out, 16'h4000);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("wshort_b1", bdata_out, 16'h4001);
    end_txn();
    chk("wshort_discard", bdata_out, 16'h0);
    push_wd(16'h5000);
    chk("wshort_next", bdata_out, 16'h5000);

    // Reset in the middle of a read burst
    push_cmd(1'b0, 16'h0400, 2'b11);
    issue("rst", 16'h0400, 2'b11, 1'b0);
    rd_beat("rst_b0", 16'hE000);
    rd_beat("rst_b1", 16'hE001);
    bvalid = 1'b1; bdata_in = 16'hEEEE;
    reset  = 1'b1;
    #1;
    chk_reset("mid");
    step();
    bvalid = 1'b0; bwait = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk_reset("post");

    // Extra bvalid after the last beat
    push_cmd(1'b0, 16'h0500, 2'b00);
    issue("extra", 16'h0500, 2'b00, 1'b0);
    rd_beat("extra_b0", 16'hC0DE);
    bvalid = 1'b1; bdata_in = 16'hDEAD;
    step();
    bvalid = 1'b0;
    chk("extra_no_rd", 16'(rd_valid), 16'h0);
    chk("extra_err", 16'(err), 16'h1);
    chk("extra_data", rd_data, 16'hC0DE);
    end_txn();

    // Burst crossing a 128-word row
    push_cmd(1'b0, 16'h007E, 2'b10);
`ifdef MICRON_SEQ_ROW_SPLIT_EN
    for (int p = 0; p < 4; p++) begin
      issue("row_piece", 16'h007E + 16'(p), 2'b00, 1'b0);
      rd_beat("row_piece", 16'h7000 + 16'(p));
      end_txn();
    end
`else
    issue("row", 16'h007E, 2'b10, 1'b0);
    for (int p = 0; p < 4; p++) rd_beat("row", 16'h7000 + 16'(p));
    end_txn();
`endif
    chk("row_done", 16'(breq), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
